// File: rtl/timer_core_if.sv
// Register access port of the timer core: one-cycle write strobe with
// word-select address and data, plus an independent combinational read port.
interface timer_core_if;
  logic        wr_en;
  logic [2:0]  wr_addr;
  logic [31:0] wr_data;
  logic [2:0]  rd_addr;
  logic [31:0] rd_data;

  // Register-interface block side: issues writes and read addresses.
  modport master (
    output wr_en,
    output wr_addr,
    output wr_data,
    output rd_addr,
    input  rd_data
  );

  // Timer core side: accepts writes and returns read data.
  modport slave (
    input  wr_en,
    input  wr_addr,
    input  wr_data,
    input  rd_addr,
    output rd_data
  );
endinterface

// File: rtl/timer_core.sv
// 64-bit timer counter with compare register, sticky match status and
// interrupt enable, accessed as 32-bit words through timer_core_if.
module timer_core #(
  parameter logic [63:0] CMP_RST = 64'hFFFF_FFFF_FFFF_FFFF
) (
  input  logic        clk,
  input  logic        rst_n,
  timer_core_if.slave bus,
  input  logic        cnt_en,
  output logic [63:0] cnt_val,
  output logic [63:0] cmp_val,
  output logic        int_st,
  output logic        tim_int
);

  localparam logic [2:0] ADDR_CNT_L  = 3'd0;
  localparam logic [2:0] ADDR_CNT_H  = 3'd1;
  localparam logic [2:0] ADDR_CMP_L  = 3'd2;
  localparam logic [2:0] ADDR_CMP_H  = 3'd3;
  localparam logic [2:0] ADDR_INT_EN = 3'd4;
  localparam logic [2:0] ADDR_INT_ST = 3'd5;

  logic [63:0] cnt_q, cnt_d;
  logic [63:0] cmp_q, cmp_d;
  logic        int_en_q, int_en_d;
  logic        int_st_q, int_st_d;

  logic        match;
  logic        cnt_wr;
  logic        st_clr;

  // Equality is judged on the registered values, so status follows one edge
  // after the counter or compare register lands on the match.
  assign match  = (cnt_q == cmp_q);
  assign cnt_wr = bus.wr_en && ((bus.wr_addr == ADDR_CNT_L) || (bus.wr_addr == ADDR_CNT_H));
  assign st_clr = bus.wr_en && (bus.wr_addr == ADDR_INT_ST) && bus.wr_data[0];

  // Next-state: register writes first; a counter write wins over the increment.
  always_comb begin
    cnt_d    = cnt_q;
    cmp_d    = cmp_q;
    int_en_d = int_en_q;
    if (bus.wr_en) begin
      case (bus.wr_addr)
        ADDR_CNT_L:  cnt_d[31:0]  = bus.wr_data;
        ADDR_CNT_H:  cnt_d[63:32] = bus.wr_data;
        ADDR_CMP_L:  cmp_d[31:0]  = bus.wr_data;
        ADDR_CMP_H:  cmp_d[63:32] = bus.wr_data;
        ADDR_INT_EN: int_en_d     = bus.wr_data[0];
        default:     ;
      endcase
    end
    if (cnt_en && !cnt_wr) begin
      cnt_d = cnt_q + 64'd1;
    end
    // A standing match re-sets the status, so it beats a simultaneous clear.
    int_st_d = match | (int_st_q & ~st_clr);
  end

  // State registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q    <= 64'd0;
      cmp_q    <= CMP_RST;
      int_en_q <= 1'b0;
      int_st_q <= 1'b0;
    end else begin
      cnt_q    <= cnt_d;
      cmp_q    <= cmp_d;
      int_en_q <= int_en_d;
      int_st_q <= int_st_d;
    end
  end

  // Read mux: current register state only, writes in flight are not forwarded.
  always_comb begin
    bus.rd_data = 32'd0;
    case (bus.rd_addr)
      ADDR_CNT_L:  bus.rd_data = cnt_q[31:0];
      ADDR_CNT_H:  bus.rd_data = cnt_q[63:32];
      ADDR_CMP_L:  bus.rd_data = cmp_q[31:0];
      ADDR_CMP_H:  bus.rd_data = cmp_q[63:32];
      ADDR_INT_EN: bus.rd_data = {31'd0, int_en_q};
      ADDR_INT_ST: bus.rd_data = {31'd0, int_st_q};
      default:     bus.rd_data = 32'd0;
    endcase
  end

  assign cnt_val = cnt_q;
  assign cmp_val = cmp_q;
  assign int_st  = int_st_q;
  assign tim_int = int_st_q & int_en_q;

endmodule

// File: tb/tb_timer_core.sv
// Directed bench for timer_core: a register-level model tracks what the
// timer must hold after each edge and is compared every cycle, with literal
// expectations along the way that pin the model itself.
module tb_timer_core;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        cnt_en = 1'b0;
  logic [63:0] cnt_val;
  logic [63:0] cmp_val;
  logic        int_st;
  logic        tim_int;

  timer_core_if bus();

  timer_core dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .bus     (bus),
    .cnt_en  (cnt_en),
    .cnt_val (cnt_val),
    .cmp_val (cmp_val),
    .int_st  (int_st),
    .tim_int (tim_int)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;
  logic [2:0] rd_sel = 3'd0;

  // Behavioural model: the four architectural registers of the timer.
  logic [63:0] m_cnt;
  logic [63:0] m_cmp;
  logic        m_ie;
  logic        m_st;
  logic        m_equal;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_cnt = 64'd0;
      m_cmp = 64'hFFFF_FFFF_FFFF_FFFF;
      m_ie  = 1'b0;
      m_st  = 1'b0;
    end else begin
      m_equal = (m_cnt == m_cmp);
      if (m_equal)
        m_st = 1'b1;
      else if (bus.wr_en && bus.wr_addr == 3'd5 && bus.wr_data[0])
        m_st = 1'b0;
      if (bus.wr_en && bus.wr_addr == 3'd0)
        m_cnt = {m_cnt[63:32], bus.wr_data};
      else if (bus.wr_en && bus.wr_addr == 3'd1)
        m_cnt = {bus.wr_data, m_cnt[31:0]};
      else if (cnt_en)
        m_cnt = m_cnt + 64'd1;
      if (bus.wr_en && bus.wr_addr == 3'd2) m_cmp = {m_cmp[63:32], bus.wr_data};
      if (bus.wr_en && bus.wr_addr == 3'd3) m_cmp = {bus.wr_data, m_cmp[31:0]};
      if (bus.wr_en && bus.wr_addr == 3'd4) m_ie = bus.wr_data[0];
    end
  end

  function automatic logic [31:0] exp_rd(input logic [2:0] a);
    case (a)
      3'd0: return m_cnt[31:0];
      3'd1: return m_cnt[63:32];
      3'd2: return m_cmp[31:0];
      3'd3: return m_cmp[63:32];
      3'd4: return {31'd0, m_ie};
      3'd5: return {31'd0, m_st};
      default: return 32'd0;
    endcase
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // One clock cycle of stimulus, entered and left at negedge+2.
  task automatic tick(input logic en, input logic we, input logic [2:0] wa, input logic [31:0] wd);
    cnt_en      = en;
    bus.wr_en   = we;
    bus.wr_addr = wa;
    bus.wr_data = wd;
    bus.rd_addr = rd_sel;
    rd_sel      = rd_sel + 3'd1;
    @(posedge clk);
    #1;
    cnt_en    = 1'b0;
    bus.wr_en = 1'b0;
    @(negedge clk);
    #2;
  endtask

  task automatic wr(input logic [2:0] wa, input logic [31:0] wd);
    tick(1'b0, 1'b1, wa, wd);
  endtask

  task automatic rd_chk(input string name, input logic [2:0] a, input logic [31:0] exp);
    bus.rd_addr = a;
    #1;
    chk(name, {32'd0, bus.rd_data}, {32'd0, exp});
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.wr_en   = 1'b0;
    bus.wr_addr = 3'd0;
    bus.wr_data = 32'd0;
    bus.rd_addr = 3'd3;
    #1 rst_n = 1'b0;
    @(negedge clk);
    #2;
    chk("rst_cnt", cnt_val, 64'd0);
    chk("rst_cmp", cmp_val, 64'hFFFF_FFFF_FFFF_FFFF);
    chk("rst_st", {63'd0, int_st}, 64'd0);
    chk("rst_rd3", {32'd0, bus.rd_data}, 64'h0000_0000_FFFF_FFFF);
    rst_n = 1'b1;

    fork
      // Per-cycle comparison of every output against the model.
      forever begin
        @(negedge clk);
        if (rst_n) begin
          chk("cyc_cnt", cnt_val, m_cnt);
          chk("cyc_cmp", cmp_val, m_cmp);
          chk("cyc_st", {63'd0, int_st}, {63'd0, m_st});
          chk("cyc_int", {63'd0, tim_int}, {63'd0, m_st & m_ie});
          chk("cyc_rd", {32'd0, bus.rd_data}, {32'd0, exp_rd(bus.rd_addr)});
        end
      end
      begin
        // Count up to compare = 10 with interrupt enabled.
        wr(3'd2, 32'd10);
        wr(3'd3, 32'd0);
        wr(3'd4, 32'd1);
        for (int i = 0; i < 10; i++) tick(1'b1, 1'b0, 3'd0, 32'd0);
        chk("cc_cnt10", cnt_val, 64'd10);
        chk("cc_st_late", {63'd0, int_st}, 64'd0);
        tick(1'b1, 1'b0, 3'd0, 32'd0);
        chk("cc_cnt11", cnt_val, 64'd11);
        chk("cc_st", {63'd0, int_st}, 64'd1);
        chk("cc_int", {63'd0, tim_int}, 64'd1);
        wr(3'd5, 32'h2);
        chk("st_wr0_keep", {63'd0, int_st}, 64'd1);
        wr(3'd5, 32'h1);
        chk("st_clr", {63'd0, int_st}, 64'd0);

        // Wrap through all-ones to zero.
        wr(3'd2, 32'd5);
        wr(3'd1, 32'hFFFF_FFFF);
        wr(3'd0, 32'hFFFF_FFFE);
        tick(1'b1, 1'b0, 3'd0, 32'd0);
        chk("wrap_ones", cnt_val, 64'hFFFF_FFFF_FFFF_FFFF);
        tick(1'b1, 1'b0, 3'd0, 32'd0);
        chk("wrap_zero", cnt_val, 64'd0);
        chk("wrap_nost", {63'd0, int_st}, 64'd0);

        // Counter write suppresses the same-cycle increment.
        wr(3'd0, 32'd100);
        chk("pri_100", cnt_val, 64'd100);
        tick(1'b1, 1'b1, 3'd0, 32'd7);
        chk("pri_l7", cnt_val, 64'd7);
        tick(1'b1, 1'b1, 3'd1, 32'd1);
        chk("pri_h1", cnt_val, 64'h0000_0001_0000_0007);

        // Standing match defeats the clear until compare moves.
        wr(3'd2, 32'd20);
        wr(3'd1, 32'd0);
        wr(3'd0, 32'd20);
        tick(1'b0, 1'b0, 3'd0, 32'd0);
        chk("hold_st", {63'd0, int_st}, 64'd1);
        wr(3'd5, 32'd1);
        chk("hold_clr_blk", {63'd0, int_st}, 64'd1);
        wr(3'd2, 32'd30);
        chk("cmp30", cmp_val, 64'd30);
        wr(3'd5, 32'd1);
        chk("cmp30_clr", {63'd0, int_st}, 64'd0);

        // Status sets with the enable off; enable exposes it next cycle.
        wr(3'd4, 32'hFFFF_FFFE);
        rd_chk("ie_bit0", 3'd4, 32'd0);
        for (int i = 0; i < 10; i++) tick(1'b1, 1'b0, 3'd0, 32'd0);
        chk("gate_cnt30", cnt_val, 64'd30);
        tick(1'b0, 1'b0, 3'd0, 32'd0);
        chk("gate_st", {63'd0, int_st}, 64'd1);
        chk("gate_noint", {63'd0, tim_int}, 64'd0);
        wr(3'd4, 32'd1);
        chk("gate_int", {63'd0, tim_int}, 64'd1);

        // Reserved words: writes ignored, reads zero.
        wr(3'd6, 32'hDEAD_BEEF);
        wr(3'd7, 32'hFFFF_FFFF);
        rd_chk("rd6", 3'd6, 32'd0);
        rd_chk("rd7", 3'd7, 32'd0);
        rd_chk("rd4", 3'd4, 32'd1);
        rd_chk("rd5", 3'd5, 32'd1);
        rd_chk("rd2", 3'd2, 32'd30);
        rd_chk("rd0", 3'd0, 32'd30);

        // Asynchronous reset in the middle of a counting cycle.
        tick(1'b1, 1'b0, 3'd0, 32'd0);
        cnt_en = 1'b1;
        bus.rd_addr = 3'd3;
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_cnt", cnt_val, 64'd0);
        chk("arst_cmp", cmp_val, 64'hFFFF_FFFF_FFFF_FFFF);
        chk("arst_st", {63'd0, int_st}, 64'd0);
        chk("arst_int", {63'd0, tim_int}, 64'd0);
        chk("arst_rd3", {32'd0, bus.rd_data}, 64'h0000_0000_FFFF_FFFF);
        @(negedge clk);
        #2;
        cnt_en = 1'b0;
        rst_n = 1'b1;
        tick(1'b1, 1'b0, 3'd0, 32'd0);
        tick(1'b1, 1'b0, 3'd0, 32'd0);
        chk("post_cnt2", cnt_val, 64'd2);
        @(negedge clk);
      end
    join_any
    disable fork;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/timer_core.md
# timer_core

Downstream consumer of the timer's clock-divider/halt stage: a 64-bit up-counter that advances by one on each cycle its count-enable pulse is high. Holds a 64-bit compare value, raises a sticky interrupt status on counter/compare equality, and gates it with an interrupt enable to produce the timer interrupt. Counter, compare and interrupt registers are written and read through a simple 32-bit word-select port driven by the register-interface block.

## Interface
- CMP_RST, 64'hFFFF_FFFF_FFFF_FFFF, reset value of the compare register
- clk  input  1  system clock; all state updates on its rising edge
- rst_n  input  1  asynchronous, active-low reset
- cnt_en  input  1  one-cycle count-enable pulse from the divider/halt stage; already gated by timer enable, division and debug halt
- wr_en  input  1  register write strobe, one cycle per write
- wr_addr  input  3  write word select: 0 CNT_L, 1 CNT_H, 2 CMP_L, 3 CMP_H, 4 INT_EN, 5 INT_ST, 6–7 reserved
- wr_data  input  32  write data
- rd_addr  input  3  read word select, same map
- rd_data  output  32  combinational read data
- cnt_val  output  64  current counter value
- cmp_val  output  64  current compare value
- int_st  output  1  sticky interrupt status
- tim_int  output  1  interrupt to the interrupt controller = int_st & INT_EN

## Operation
- Reset values: cnt_val 0, cmp_val CMP_RST, INT_EN 0, int_st 0, tim_int 0, rd_data = value selected by rd_addr from reset state.
- Counter priority per cycle: write to CNT_L loads bits [31:0], bits [63:32] unchanged; write to CNT_H loads [63:32], [31:0] unchanged; a write to either word suppresses that cycle's increment, even with cnt_en high. Otherwise cnt_en=1 -> cnt_val+1, modulo 2^64 (all-ones wraps to 0, no flag). Otherwise hold.
- Compare: write to CMP_L / CMP_H loads the addressed 32-bit half; other half unchanged. No increment interaction.
- INT_EN: write to addr 4 loads wr_data[0]; wr_data[31:1] ignored.
- Match: match = (cnt_val == cmp_val), evaluated on current registered values, full 64 bits.
- int_st: next = match | (int_st & ~clr), where clr = wr_en & wr_addr==5 & wr_data[0]. Writing 0 to bit 0 has no effect. Set has priority over clear: with match held, a clear is ineffective and int_st stays 1.
- Match is level-based: while cnt_en stays low after reaching cmp_val, match persists and int_st cannot be cleared until counter or compare changes.
- INT_EN does not gate int_st; int_st sets regardless, and tim_int asserts immediately when INT_EN is later set.
- Reserved writes (6, 7) change nothing. Reads of 6, 7 return 0; reads of 4 and 5 return {31'b0, bit}.
- Asynchronous reset mid-operation clears all state immediately, including any int_st set in the same cycle.

## Timing
- Counter, compare, INT_EN, int_st are registers; cnt_val, cmp_val, int_st, rd_data reflect a write on the cycle after the wr_en edge.
- Increment latency: cnt_en high at edge N -> cnt_val updated after edge N.
- Interrupt latency: cnt_val becomes equal to cmp_val after edge N -> int_st and tim_int (INT_EN=1) high after edge N+1.
- Compare write producing equality: int_st high one edge after cmp_val updates.
- tim_int is combinational from int_st and INT_EN; no extra cycle.
- rd_data is purely combinational from rd_addr and current register state; a same-cycle write is not forwarded.

## Test plan
- Reset: assert rst_n=0 mid-count -> cnt_val=0, cmp_val=all-ones, int_st=0, tim_int=0 immediately; rd_addr=3 reads 32'hFFFF_FFFF.
- Count/compare: cmp_val=10, INT_EN=1, cnt_en high continuously from 0 -> cnt_val=10 after 10th edge, int_st/tim_int=1 one edge later, cnt_val=11.
- Wrap: write CNT_H=32'hFFFF_FFFF, CNT_L=32'hFFFF_FFFE, pulse cnt_en twice -> 64'hFFFF_FFFF_FFFF_FFFF then 0; no int_st (cmp=5).
- Write priority: cnt_val=100, cnt_en=1 same cycle as CNT_L write of 7 -> cnt_val=7 next cycle, not 8 or 101.
- Clear vs set: counter held at cmp_val=20, write INT_ST=1 -> int_st stays 1; change cmp to 30, clear -> int_st=0.
- Enable gating: INT_EN=0, reach match -> int_st=1, tim_int=0; write INT_EN=1 -> tim_int=1 next cycle.
